pulse_capture_ctrl: RTL and testbench

//  Sequences single-pulse timing capture on an asynchronous board pin (PIN_2 on the TinyFPGA top).

---
 rtl/pulse_capture_ctrl_pkg.sv | 25 ++
 rtl/pulse_capture_ctrl_pin_sync_edge.sv | 41 ++++
 rtl/pulse_capture_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pulse_capture_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_capture_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pulse_ctrl_pkg                                                   |
// | Brief   : State encoding and default widths for pulse_capture_ctrl.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pulse_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOW  = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_REPORT    = 3'd4,
    ST_DEAD      = 3'd5
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEAD_CYCLES = 8;
  localparam int DEF_LED_HOLD_W  = 20;
  localparam int DEF_TIMEOUT_CYC = 60000;

endpackage
`default_nettype wire

// File: rtl/pulse_capture_ctrl_pin_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pin_sync_edge                                                    |
// | Brief   : Multi-stage synchroniser for an async pin plus rise/fall detect. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic pin_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];
  assign rise  = pin_s & ~prev_q;
  assign fall  = ~pin_s & prev_q;

endmodule
`default_nettype wire

// File: rtl/pulse_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pulse_capture_ctrl                                               |
// | Brief   : Arms on request, measures arm-to-rise delay and high width of    |
// |           one pulse, reports via valid/ready, stretches an LED per result. |
// |           Optional macro PULSE_TIMEOUT_EN aborts over-long pulses.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pulse_capture_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int LED_HOLD_W  = DEF_LED_HOLD_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PIN_IN,
  input  logic             ARM,
  input  logic             CONTINUOUS,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [CNT_W-1:0] RES_DELAY,
  output logic [CNT_W-1:0] RES_WIDTH,
  output logic             RES_OVF,
  output logic             RES_TMO,
  output logic             BUSY,
  output logic             LED
);

`ifdef PULSE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam int               DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  logic pin_s, rise, fall;

  pin_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .rst    (RST),
    .pin_in (PIN_IN),
    .pin_s  (pin_s),
    .rise   (rise),
    .fall   (fall)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      delay_q, delay_d;
  logic [CNT_W-1:0]      width_q, width_d;
  logic                  ovf_q, ovf_d;
  logic [DEAD_W-1:0]     dead_q, dead_d;
  logic                  valid_q, valid_d;
  logic [CNT_W-1:0]      res_delay_q, res_delay_d;
  logic [CNT_W-1:0]      res_width_q, res_width_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  res_tmo_q, res_tmo_d;
  logic [LED_HOLD_W-1:0] led_q, led_d;

  logic handshake;
  logic tmo_hit;

  assign handshake = valid_q & RES_READY;
  assign tmo_hit   = TMO_EN && (width_q == TMO_LIMIT);

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    width_d     = width_q;
    ovf_d       = ovf_q;
    dead_d      = dead_q;
    valid_d     = 1'b0;
    res_delay_d = res_delay_q;
    res_width_d = res_width_q;
    res_ovf_d   = res_ovf_q;
    res_tmo_d   = res_tmo_q;

    case (state_q)
      ST_IDLE: begin
        delay_d = '0;
        width_d = '0;
        ovf_d   = 1'b0;
        if (ARM) state_d = ST_WAIT_LOW;
      end

      // Re-armed captures also pass through here, so counters restart cleanly.
      ST_WAIT_LOW: begin
        delay_d = '0;
        width_d = '0;
        ovf_d   = 1'b0;
        if (!pin_s) state_d = ST_WAIT_RISE;
      end

      ST_WAIT_RISE: begin
        if (delay_q == CNT_SAT) ovf_d = 1'b1;
        else                    delay_d = delay_q + CNT_W'(1);
        if (rise) begin
          width_d = CNT_W'(1);
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        if (fall || tmo_hit) begin
          res_delay_d = delay_q;
          res_width_d = width_q;
          res_ovf_d   = ovf_q;
          res_tmo_d   = ~fall;
          state_d     = ST_REPORT;
        end else if (pin_s) begin
          if (width_q == CNT_SAT) ovf_d = 1'b1;
          else                    width_d = width_q + CNT_W'(1);
        end
      end

      // RES_VALID trails state entry by one cycle; the handshake keys off it.
      ST_REPORT: begin
        if (handshake) begin
          dead_d  = '0;
          state_d = ST_DEAD;
        end else begin
          valid_d = 1'b1;
        end
      end

      ST_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          state_d = CONTINUOUS ? ST_WAIT_LOW : ST_IDLE;
        end else begin
          dead_d = dead_q + DEAD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (handshake)         led_d = {LED_HOLD_W{1'b1}};
    else if (led_q != '0)  led_d = led_q - LED_HOLD_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      delay_q     <= '0;
      width_q     <= '0;
      ovf_q       <= 1'b0;
      dead_q      <= '0;
      valid_q     <= 1'b0;
      res_delay_q <= '0;
      res_width_q <= '0;
      res_ovf_q   <= 1'b0;
      res_tmo_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      ovf_q       <= ovf_d;
      dead_q      <= dead_d;
      valid_q     <= valid_d;
      res_delay_q <= res_delay_d;
      res_width_q <= res_width_d;
      res_ovf_q   <= res_ovf_d;
      res_tmo_q   <= res_tmo_d;
      led_q       <= led_d;
    end
  end

  assign RES_VALID = valid_q;
  assign RES_DELAY = res_delay_q;
  assign RES_WIDTH = res_width_q;
  assign RES_OVF   = res_ovf_q;
  assign RES_TMO   = res_tmo_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign LED       = (led_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_pulse_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pulse_capture_ctrl                                            |
// | Brief   : Directed, table-driven self-checking bench for pulse_capture_ctrl|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pulse_capture_ctrl;

  localparam int SYNC = 2;
  localparam int DEAD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, pin = 1'b0, arm = 1'b0, cont = 1'b0, ready = 1'b0;
  logic        valid, ovf, tmo, busy, led;
  logic [15:0] rdelay, rwidth;

  logic        pin2 = 1'b0, arm2 = 1'b0, ready2 = 1'b0;
  logic        valid2, ovf2, tmo2, busy2, led2;
  logic [7:0]  rdelay2, rwidth2;

  pulse_capture_ctrl #(
    .CNT_W(16), .SYNC_STAGES(SYNC), .DEAD_CYCLES(DEAD), .LED_HOLD_W(20), .TIMEOUT_CYC(60000)
  ) dut (
    .CLK(clk), .RST(rst), .PIN_IN(pin), .ARM(arm), .CONTINUOUS(cont),
    .RES_VALID(valid), .RES_READY(ready), .RES_DELAY(rdelay), .RES_WIDTH(rwidth),
    .RES_OVF(ovf), .RES_TMO(tmo), .BUSY(busy), .LED(led)
  );

  pulse_capture_ctrl #(
    .CNT_W(8), .SYNC_STAGES(SYNC), .DEAD_CYCLES(DEAD), .LED_HOLD_W(4), .TIMEOUT_CYC(100)
  ) dut2 (
    .CLK(clk), .RST(rst), .PIN_IN(pin2), .ARM(arm2), .CONTINUOUS(1'b0),
    .RES_VALID(valid2), .RES_READY(ready2), .RES_DELAY(rdelay2), .RES_WIDTH(rwidth2),
    .RES_OVF(ovf2), .RES_TMO(tmo2), .BUSY(busy2), .LED(led2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int rise_after;
    int high;
    int exp_delay;
    int exp_width;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!valid && lat < 2000) begin
      tick(1);
      lat++;
    end
    if (!valid) chk({name, "_timeout"}, 0, 1);
  endtask

  // One full capture: rise placed rise_after cycles after WAIT_RISE entry.
  task automatic run_main(input string tag, input int ra, input int high,
                          input int exp_d, input int exp_w);
    int lat;
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(1 + ra);
    pin = 1'b1; tick(high); pin = 1'b0;
    wait_valid(tag, lat);
    chk({tag, "_latency"}, lat, SYNC + 2);
    chk({tag, "_delay"}, rdelay, exp_d);
    chk({tag, "_width"}, rwidth, exp_w);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_busy"}, busy, 1);
    ready = 1'b1; tick(1); ready = 1'b0;
    chk({tag, "_valid_drop"}, valid, 0);
    chk({tag, "_led_on"}, led, 1);
    tick(DEAD - 1);
    chk({tag, "_dead_busy"}, busy, 1);
    tick(1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad, nres, ledbad;
    logic [15:0] hold_d, hold_w;

    vecs[0] = '{250, 260, 253, 260};
    vecs[1] = '{0,   1,   3,   1};
    vecs[2] = '{5,   1,   8,   1};
    vecs[3] = '{17,  3,   20,  3};
    vecs[4] = '{100, 40,  103, 40};

    // Reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_led", led, 0);
    chk("rst_delay", rdelay, 0);
    chk("rst_width", rwidth, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    tick(2);

    foreach (vecs[i])
      run_main($sformatf("v%0d", i), vecs[i].rise_after, vecs[i].high,
               vecs[i].exp_delay, vecs[i].exp_width);

    // Pin already high at ARM: first pulse must be ignored
    pin = 1'b1; tick(4);
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(99); pin = 1'b0;
    tick(20); pin = 1'b1;
    tick(40); pin = 1'b0;
    wait_valid("prehigh", lat);
    chk("prehigh_delay", rdelay, 20);
    chk("prehigh_width", rwidth, 40);
    ready = 1'b1; tick(1); ready = 1'b0;
    tick(DEAD);
    chk("prehigh_idle", busy, 0);

    // Backpressure: result held for 500 cycles, ARM and pin activity ignored
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(31); pin = 1'b1; tick(12); pin = 1'b0;
    wait_valid("hold", lat);
    hold_d = rdelay; hold_w = rwidth;
    chk("hold_delay", hold_d, 33);
    chk("hold_width", hold_w, 12);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      arm = (i % 50 == 0);
      pin = (i % 97 < 5);
      tick(1);
      if (!valid || !busy || rdelay != hold_d || rwidth != hold_w) bad++;
    end
    arm = 1'b0; pin = 1'b0;
    chk("hold_unstable_cycles", bad, 0);
    ready = 1'b1; tick(1); ready = 1'b0;
    chk("hold_release", valid, 0);
    tick(DEAD);
    chk("hold_no_rearm", busy, 0);

    // Continuous mode: three 10-cycle pulses, 50 cycles apart
    cont = 1'b1; ready = 1'b1;
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(5);
    nres = 0; ledbad = 0;
    for (int p = 0; p < 3; p++) begin
      pin = 1'b1; tick(10); pin = 1'b0;
      if (p == 2) cont = 1'b0;
      for (int j = 0; j < 50; j++) begin
        tick(1);
        if (nres >= 1 && !led) ledbad++;
        if (valid) begin
          nres++;
          chk($sformatf("cont_width%0d", nres), rwidth, 10);
        end
      end
    end
    ready = 1'b0;
    chk("cont_results", nres, 3);
    chk("cont_led_gaps", ledbad, 0);
    chk("cont_final_idle", busy, 0);

    // Narrow counters: width saturation or timeout, then LED stretch decay
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    tick(3); pin2 = 1'b1; tick(300); pin2 = 1'b0;
    lat = 0;
    while (!valid2 && lat < 400) begin tick(1); lat++; end
    chk("long_valid", valid2, 1);
`ifdef PULSE_TIMEOUT_EN
    chk("long_width", rwidth2, 100);
    chk("long_tmo", tmo2, 1);
    chk("long_ovf", ovf2, 0);
`else
    chk("long_width", rwidth2, 255);
    chk("long_tmo", tmo2, 0);
    chk("long_ovf", ovf2, 1);
`endif
    ready2 = 1'b1; tick(1); ready2 = 1'b0;
    tick(14);
    chk("led2_last_on", led2, 1);
    tick(1);
    chk("led2_off", led2, 0);
    chk("long_idle", busy2, 0);

    // Delay saturation
    arm2 = 1'b1; tick(1); arm2 = 1'b0;
    tick(301); pin2 = 1'b1; tick(5); pin2 = 1'b0;
    lat = 0;
    while (!valid2 && lat < 100) begin tick(1); lat++; end
    chk("dsat_valid", valid2, 1);
    chk("dsat_delay", rdelay2, 255);
    chk("dsat_ovf", ovf2, 1);
    chk("dsat_width", rwidth2, 5);
    chk("dsat_tmo", tmo2, 0);
    ready2 = 1'b1; tick(1); ready2 = 1'b0;
    tick(DEAD);

    // Reset mid-MEASURE
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(3); pin = 1'b1; tick(20);
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_led", led, 1);
    rst = 1'b1; tick(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_led", led, 0);
    chk("midrst_width", rwidth, 0);
    chk("midrst_delay", rdelay, 0);
    rst = 1'b0; pin = 1'b0;
    tick(3);
    run_main("post_rst", 25, 30, 28, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
